// File: rtl/prog_loader_if.sv
// Byte-stream input and CPU-memory external write port of the program loader.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        Ext_MemWrite;
  logic [31:0] Ext_DataAdr;
  logic [31:0] Ext_WriteData;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  Ext_MemWrite, Ext_DataAdr, Ext_WriteData
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output Ext_MemWrite, Ext_DataAdr, Ext_WriteData
  );
endinterface

// File: rtl/prog_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to CPU memory; strobe one cycle after the completing byte.
// Backpressure: in_ready drops during the write cycle and outside LOAD, so peak rate is 4 bytes per 5 cycles.
module prog_loader #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH_WORDS);

  state_t      state, nextState;
  logic [1:0]  byteIdx;
  logic [31:0] wordBuf, nextBuf, addr, adrQ, dataQ;
  logic [15:0] wordCount;
  logic        lastSeen;
  logic        inReady, memWrite, accept, wordDone;

  assign accept   = bus.in_valid && inReady;
  assign wordDone = accept && ((byteIdx == 2'd3) || bus.in_last);

  always_comb begin
    nextBuf = wordBuf;
    case (byteIdx)
      2'd0: nextBuf[7:0]   = bus.in_data;
      2'd1: nextBuf[15:8]  = bus.in_data;
      2'd2: nextBuf[23:16] = bus.in_data;
      default: nextBuf[31:24] = bus.in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE, ERR: if (start) nextState = LOAD;
      LOAD:            if (wordDone) nextState = WRITE;
      WRITE: begin
        // A terminating byte wins over the depth limit on the final word.
        if (lastSeen)                          nextState = DONE;
        else if (wordCount + 16'd1 == DEPTH16) nextState = ERR;
        else                                   nextState = LOAD;
      end
      default: nextState = IDLE;
    endcase
  end

  // Reset gates the handshake and strobe combinationally so a reset cycle never accepts or writes.
  always_comb begin
    inReady   = 1'b0;
    memWrite  = 1'b0;
    cpu_reset = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      LOAD: begin
        inReady = !reset;
        busy    = 1'b1;
      end
      WRITE: begin
        memWrite = !reset;
        busy     = 1'b1;
      end
      DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byteIdx   <= 2'd0;
      wordBuf   <= 32'd0;
      addr      <= 32'd0;
      wordCount <= 16'd0;
      lastSeen  <= 1'b0;
      adrQ      <= 32'd0;
      dataQ     <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            byteIdx   <= 2'd0;
            wordBuf   <= 32'd0;
            wordCount <= 16'd0;
            addr      <= BASE_ADDR;
            lastSeen  <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            wordBuf  <= nextBuf;
            byteIdx  <= byteIdx + 2'd1;
            lastSeen <= bus.in_last;
            if (wordDone) begin
              adrQ  <= addr;
              dataQ <= nextBuf;
            end
          end
        end
        WRITE: begin
          addr      <= addr + 32'd4;
          wordCount <= wordCount + 16'd1;
          wordBuf   <= 32'd0;
          byteIdx   <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = inReady;
  assign bus.Ext_MemWrite  = memWrite;
  assign bus.Ext_DataAdr   = adrQ;
  assign bus.Ext_WriteData = dataQ;
  assign word_count        = wordCount;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench: per-cycle vector table on the default loader, plus an overflow/wrap sequence on a 2-word instance.
module tb_prog_loader;

  logic clk;
  logic rstA, startA, rstB, startB;
  logic cpuA, busyA, doneA, errA;
  logic cpuB, busyB, doneB, errB;
  logic [15:0] wcA, wcB;

  prog_loader_if pif ();
  prog_loader_if qif ();

  prog_loader dutA (
    .clk(clk), .reset(rstA), .start(startA), .bus(pif.slave),
    .cpu_reset(cpuA), .busy(busyA), .done(doneA), .err(errA), .word_count(wcA)
  );

  prog_loader #(.DEPTH_WORDS(2), .BASE_ADDR(32'hFFFF_FFFC)) dutB (
    .clk(clk), .reset(rstB), .start(startB), .bus(qif.slave),
    .cpu_reset(cpuB), .busy(busyB), .done(doneB), .err(errB), .word_count(wcB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, v, last;
    logic [7:0]  d;
    logic        rdy, mw, cpu, bz, dn, er;
    logic [31:0] adr, wd;
    logic [15:0] wc;
  } vec_t;

  vec_t tv[$];
  int   nPass = 0;
  int   nTotal = 0;

  function automatic vec_t mk(logic rst, logic st, logic v, logic last, logic [7:0] d,
                              logic rdy, logic mw, logic cpu, logic bz, logic dn, logic er,
                              logic [31:0] adr, logic [31:0] wd, logic [15:0] wc);
    vec_t r;
    r.rst = rst; r.st = st; r.v = v; r.last = last; r.d = d;
    r.rdy = rdy; r.mw = mw; r.cpu = cpu; r.bz = bz; r.dn = dn; r.er = er;
    r.adr = adr; r.wd = wd; r.wc = wc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  logic [127:0] actV, expV;
  int           nSent, nStrobe;
  logic [31:0]  sAdr[2];
  logic [31:0]  sDat[2];

  initial begin
    rstA = 1'b1; startA = 1'b0; rstB = 1'b1; startB = 1'b0;
    pif.in_valid = 1'b0; pif.in_data = 8'h0; pif.in_last = 1'b0;
    qif.in_valid = 1'b0; qif.in_data = 8'h0; qif.in_last = 1'b0;

    // Columns: rst st v last data | rdy mw cpuRst busy done err | adr wdata wcount
    tv.push_back(mk(1,1,1,0,8'h13, 0,0,1,0,0,0, 32'h0, 32'h0, 16'd0));
    tv.push_back(mk(0,1,1,0,8'hEE, 0,0,1,0,0,0, 32'h0, 32'h0, 16'd0));
    tv.push_back(mk(0,0,1,0,8'h13, 1,0,1,1,0,0, 32'h0, 32'h0, 16'd0));
    tv.push_back(mk(0,0,1,0,8'h05, 1,0,1,1,0,0, 32'h0, 32'h0, 16'd0));
    tv.push_back(mk(0,0,1,0,8'hA0, 1,0,1,1,0,0, 32'h0, 32'h0, 16'd0));
    tv.push_back(mk(0,0,1,1,8'h00, 1,0,1,1,0,0, 32'h0, 32'h0, 16'd0));
    tv.push_back(mk(0,0,0,0,8'h00, 0,1,1,1,0,0, 32'h0, 32'h00A00513, 16'd0));
    tv.push_back(mk(0,0,1,1,8'hFF, 0,0,0,0,1,0, 32'h0, 32'h00A00513, 16'd1));
    tv.push_back(mk(0,1,0,0,8'h00, 0,0,0,0,1,0, 32'h0, 32'h00A00513, 16'd1));
    tv.push_back(mk(0,0,0,0,8'h00, 1,0,1,1,0,0, 32'h0, 32'h00A00513, 16'd0));
    tv.push_back(mk(0,1,1,0,8'h01, 1,0,1,1,0,0, 32'h0, 32'h00A00513, 16'd0));
    tv.push_back(mk(0,0,0,1,8'h55, 1,0,1,1,0,0, 32'h0, 32'h00A00513, 16'd0));
    tv.push_back(mk(0,0,1,0,8'h02, 1,0,1,1,0,0, 32'h0, 32'h00A00513, 16'd0));
    tv.push_back(mk(0,0,1,0,8'h03, 1,0,1,1,0,0, 32'h0, 32'h00A00513, 16'd0));
    tv.push_back(mk(0,0,1,0,8'h04, 1,0,1,1,0,0, 32'h0, 32'h00A00513, 16'd0));
    tv.push_back(mk(0,1,1,0,8'h99, 0,1,1,1,0,0, 32'h0, 32'h04030201, 16'd0));
    tv.push_back(mk(0,0,1,0,8'h05, 1,0,1,1,0,0, 32'h0, 32'h04030201, 16'd1));
    tv.push_back(mk(0,0,1,0,8'h06, 1,0,1,1,0,0, 32'h0, 32'h04030201, 16'd1));
    tv.push_back(mk(0,0,0,0,8'h00, 1,0,1,1,0,0, 32'h0, 32'h04030201, 16'd1));
    tv.push_back(mk(0,0,1,0,8'h07, 1,0,1,1,0,0, 32'h0, 32'h04030201, 16'd1));
    tv.push_back(mk(0,0,1,0,8'h08, 1,0,1,1,0,0, 32'h0, 32'h04030201, 16'd1));
    tv.push_back(mk(0,0,0,0,8'h00, 0,1,1,1,0,0, 32'h4, 32'h08070605, 16'd1));
    tv.push_back(mk(0,0,1,1,8'hAA, 1,0,1,1,0,0, 32'h4, 32'h08070605, 16'd2));
    tv.push_back(mk(0,0,0,0,8'h00, 0,1,1,1,0,0, 32'h8, 32'h000000AA, 16'd2));
    tv.push_back(mk(0,0,0,0,8'h00, 0,0,0,0,1,0, 32'h8, 32'h000000AA, 16'd3));
    tv.push_back(mk(0,1,0,0,8'h00, 0,0,0,0,1,0, 32'h8, 32'h000000AA, 16'd3));
    tv.push_back(mk(0,0,1,0,8'h11, 1,0,1,1,0,0, 32'h8, 32'h000000AA, 16'd0));
    tv.push_back(mk(0,0,1,0,8'h22, 1,0,1,1,0,0, 32'h8, 32'h000000AA, 16'd0));
    tv.push_back(mk(1,0,1,0,8'h33, 0,0,1,1,0,0, 32'h8, 32'h000000AA, 16'd0));
    tv.push_back(mk(0,0,0,0,8'h00, 0,0,1,0,0,0, 32'h0, 32'h0, 16'd0));
    tv.push_back(mk(0,1,0,0,8'h00, 0,0,1,0,0,0, 32'h0, 32'h0, 16'd0));
    tv.push_back(mk(0,0,1,1,8'h44, 1,0,1,1,0,0, 32'h0, 32'h0, 16'd0));
    tv.push_back(mk(1,0,0,0,8'h00, 0,0,1,1,0,0, 32'h0, 32'h00000044, 16'd0));
    tv.push_back(mk(0,0,0,0,8'h00, 0,0,1,0,0,0, 32'h0, 32'h0, 16'd0));

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      rstA = tv[i].rst; startA = tv[i].st;
      pif.in_valid = tv[i].v; pif.in_last = tv[i].last; pif.in_data = tv[i].d;
      @(negedge clk);
      actV = {42'd0, pif.in_ready, pif.Ext_MemWrite, cpuA, busyA, doneA, errA,
              pif.Ext_DataAdr, pif.Ext_WriteData, wcA};
      expV = {42'd0, tv[i].rdy, tv[i].mw, tv[i].cpu, tv[i].bz, tv[i].dn, tv[i].er,
              tv[i].adr, tv[i].wd, tv[i].wc};
      chk($sformatf("vec%0d", i), actV, expV);
      @(posedge clk);
      #1;
    end
    rstA = 1'b0; startA = 1'b0; pif.in_valid = 1'b0; pif.in_last = 1'b0;

    // Overflow with address wrap: 12 bytes offered, no last, depth of 2 words.
    rstB = 1'b0;
    startB = 1'b1;
    @(posedge clk);
    #1;
    startB = 1'b0;
    nSent = 0; nStrobe = 0;
    sAdr[0] = 32'h0; sAdr[1] = 32'h0; sDat[0] = 32'h0; sDat[1] = 32'h0;
    for (int c = 0; c < 60; c++) begin
      qif.in_valid = (nSent < 12);
      qif.in_data  = 8'(nSent);
      @(negedge clk);
      if (errB) break;
      if (qif.Ext_MemWrite) begin
        if (nStrobe < 2) begin
          sAdr[nStrobe] = qif.Ext_DataAdr;
          sDat[nStrobe] = qif.Ext_WriteData;
        end
        nStrobe++;
      end
      if (qif.in_valid && qif.in_ready) nSent++;
      @(posedge clk);
      #1;
    end
    chk("ovf_err", 128'(errB), 128'd1);
    chk("ovf_strobes", 128'(nStrobe), 128'd2);
    chk("ovf_adr0", 128'(sAdr[0]), 128'hFFFF_FFFC);
    chk("ovf_dat0", 128'(sDat[0]), 128'h0302_0100);
    chk("ovf_adr1", 128'(sAdr[1]), 128'h0);
    chk("ovf_dat1", 128'(sDat[1]), 128'h0706_0504);
    chk("ovf_accepted", 128'(nSent), 128'd8);
    chk("ovf_status", 128'({cpuB, qif.in_ready, doneB, busyB, wcB}), 128'({1'b1, 1'b0, 1'b0, 1'b0, 16'd2}));
    qif.in_valid = 1'b0;
    @(posedge clk);
    #1;
    startB = 1'b1;
    @(posedge clk);
    #1;
    startB = 1'b0;
    @(negedge clk);
    chk("ovf_restart", 128'({errB, qif.in_ready, cpuB, wcB}), 128'({1'b0, 1'b1, 1'b1, 16'd0}));

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning the maximum number of 32-bit words loadable.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, meaning the byte address of the first written word.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a load, sampled per cycle.
REQ-006 SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port in_data  input  8  program byte, little-endian order.
REQ-008 SHALL have port in_last  input  1  marks the final byte of the program, qualified by in_valid.
REQ-009 SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both 1.
REQ-010 SHALL have port Ext_MemWrite  output  1  one-cycle write strobe to the CPU memory external port.
REQ-011 SHALL have port Ext_DataAdr  output  32  word byte address.
REQ-012 SHALL have port Ext_WriteData  output  32  assembled word.
REQ-013 SHALL have port cpu_reset  output  1  holds the CPU in reset while high.
REQ-014 SHALL have ports busy, done, err  output  1 each  status flags; word_count  output  16  words written this load.

Function
REQ-015 SHALL implement states IDLE, LOAD, WRITE, DONE, ERR.
REQ-016 IDLE: in_ready=0, cpu_reset=1; start=1 SHALL go to LOAD, clear byte index, word_count and word buffer, and set address=BASE_ADDR.
REQ-017 LOAD: in_ready=1, busy=1; each accepted byte SHALL go into lane byte_idx (first byte to [7:0], fourth byte to [31:24]), then byte_idx SHALL increment.
REQ-018 LOAD SHALL go to WRITE on the accept of the fourth byte (byte_idx==3) or of any byte with in_last=1; unfilled lanes SHALL be zero.
REQ-019 WRITE: in_ready=0 and Ext_MemWrite=1 for exactly one cycle, with Ext_DataAdr=current address and Ext_WriteData=buffer.
REQ-020 On leaving WRITE: address SHALL add 4, word_count SHALL add 1, and buffer and byte_idx SHALL clear.
REQ-021 Leaving WRITE SHALL go to DONE if the last byte was latched; otherwise to ERR if the new word_count==DEPTH_WORDS; otherwise to LOAD.
REQ-022 Latency: the write strobe SHALL be in the cycle directly after the completing byte accept; peak throughput SHALL be 4 bytes per 5 cycles.
REQ-023 DONE: cpu_reset=0, done=1, in_ready=0; start=1 SHALL re-enter LOAD with cpu_reset=1 from the next cycle.
REQ-024 ERR: cpu_reset=1, err=1, in_ready=0; start=1 SHALL re-enter LOAD and clear err.
REQ-025 start SHALL be ignored in LOAD and WRITE.
REQ-026 A byte offered in the same cycle as start in IDLE SHALL NOT be accepted.
REQ-027 Ext_MemWrite SHALL be 0 in every state except WRITE.
REQ-028 Ext_DataAdr and Ext_WriteData SHALL hold their last values outside WRITE.
REQ-029 Address SHALL wrap modulo 2^32 with no flag.
REQ-030 in_last SHALL be ignored when in_valid=0.

Reset
REQ-031 reset=1 SHALL force IDLE in any state, including mid-word and during WRITE, with no write strobe in that cycle.
REQ-032 After reset, outputs SHALL be: cpu_reset=1, in_ready=0, Ext_MemWrite=0, Ext_DataAdr=0, Ext_WriteData=0, busy=0, done=0, err=0, word_count=0.
REQ-033 reset SHALL take priority over start and over any byte handshake in the same cycle.

Verification
REQ-034 Full-word load: start, then bytes 13,05,A0,00 with last on 00 -> one strobe, Adr=0x0, Data=0x00A00513, then DONE, cpu_reset=0, word_count=1.
REQ-035 Partial word: 8 bytes, then 0xAA with last -> strobes at 0x0, 0x4, and 0x8 with Data=0x000000AA, word_count=3.
REQ-036 Overflow: DEPTH_WORDS=2, 12 bytes without last -> two strobes then ERR, err=1, cpu_reset=1, in_ready=0.
REQ-037 Reset mid-word after 2 bytes -> no strobe, IDLE, all outputs at reset values; a fresh load restarts at BASE_ADDR.
REQ-038 Backpressure: in_valid toggling randomly, start pulsed during LOAD -> start ignored, byte order and addresses intact.
REQ-039 Reload from DONE: start -> cpu_reset=1 next cycle, word_count=0, addresses restart at BASE_ADDR.
